// File: rtl/mul_pkg.sv
// Shared encodings for the radix-4 Booth multiplier: FSM states, Booth digits
// and the recode table.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    PM1  = 3'd1,
    MM1  = 3'd2,
    PM2  = 3'd3,
    MM2  = 3'd4
  } booth_dig_e;

  // Window is {Q[1], Q[0], q_1}.
  function automatic booth_dig_e booth_digit(input logic [2:0] bits);
    case (bits)
      3'b001, 3'b010: return PM1;
      3'b011:         return PM2;
      3'b100:         return MM2;
      3'b101, 3'b110: return MM1;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Combinational radix-4 Booth recoder: turns a 3-bit multiplier window into a
// signed addend of 0, +/-M or +/-2M at N+3 bits.
module booth_r4_recoder
  import mul_pkg::*;
#(
  parameter int N = 64
) (
  input  logic                  [2:0] bits,
  input  logic signed [N-1:0]         m,
  output logic signed [N+2:0]         addend
);

  booth_dig_e               digit;
  logic signed [N+2:0]      m_ext;

  always_comb begin
    addend = '0;
    digit  = booth_digit(bits);
    m_ext  = {{3{m[N-1]}}, m};
    case (digit)
      PM1:     addend = m_ext;
      MM1:     addend = -m_ext;
      PM2:     addend = m_ext <<< 1;
      MM2:     addend = -(m_ext <<< 1);
      default: addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_mul_ctrl.sv
// Sequential signed radix-4 Booth multiplier: one digit per EXEC cycle,
// N/2 iterations, registered 2N-bit product with busy/done decoded from state.
module booth_r4_mul_ctrl
  import mul_pkg::*;
#(
  parameter int N     = 64,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_start,
  input  logic              op_clear,
  input  logic [N-1:0]      multiplicand,
  input  logic [N-1:0]      multiplier,
  output logic [2*N-1:0]    result,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N/2 - 1);

  state_e                   state_q, state_d;
  logic signed [N:0]        a_q, a_d;
  logic        [N-1:0]      q_q, q_d;
  logic                     q1_q, q1_d;
  logic signed [N-1:0]      m_q, m_d;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic        [2*N-1:0]    result_q, result_d;

  logic signed [N+2:0]      addend;
  logic signed [N+2:0]      a_ext;
  logic signed [N+2:0]      sum;
  logic        [N:0]        a_next;
  logic        [N-1:0]      q_next;

  booth_r4_recoder #(.N(N)) u_recoder (
    .bits   ({q_q[1:0], q1_q}),
    .m      (m_q),
    .addend (addend)
  );

  // Add at N+3 bits so +/-2M of the most negative M cannot overflow; the
  // divide-by-4 back to N+1 bits is exact.
  always_comb begin
    a_ext  = {{2{a_q[N]}}, a_q};
    sum    = a_ext + addend;
    a_next = sum[N+2:2];
    q_next = {sum[1:0], q_q[N-1:2]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      q_q      <= '0;
      q1_q     <= 1'b0;
      m_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      q_q      <= q_d;
      q1_q     <= q1_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (op_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (op_start) state_d = EXEC;
        EXEC:       if (cnt_q == LAST) state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    a_d      = a_q;
    q_d      = q_q;
    q1_d     = q1_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (op_clear) begin
      a_d      = '0;
      q_d      = '0;
      q1_d     = 1'b0;
      m_d      = '0;
      cnt_d    = '0;
      result_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (op_start) begin
            a_d   = '0;
            q_d   = multiplier;
            q1_d  = 1'b0;
            m_d   = multiplicand;
            cnt_d = '0;
          end
        end
        EXEC: begin
          a_d   = a_next;
          q_d   = q_next;
          q1_d  = q_q[1];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            cnt_d    = '0;
            result_d = {a_next[N-1:0], q_next};
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy   = (state_q == EXEC);
    done   = (state_q == DONE);
    result = result_q;
  end

endmodule

// File: tb/tb_booth_r4_mul_ctrl.sv
// Scoreboard bench for booth_r4_mul_ctrl: stimulus pushes reference products,
// a monitor pops them on each rising done and checks value and latency.
module tb_booth_r4_mul_ctrl;

  localparam int N   = 64;
  localparam int LAT = N / 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              op_start = 1'b0;
  logic              op_clear = 1'b0;
  logic [N-1:0]      multiplicand = '0;
  logic [N-1:0]      multiplier = '0;
  logic [2*N-1:0]    result;
  logic              busy;
  logic              done;

  booth_r4_mul_ctrl #(.N(N), .CNT_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .result       (result),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*N-1:0] prod;
    int             cyc;
  } item_t;

  item_t sb[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [2*N-1:0] ea, eb;
    ea = $signed(a);
    eb = $signed(b);
    return ea * eb;
  endfunction

  task automatic chk(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    item_t it;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    op_start     = 1'b1;
    @(posedge clk);
    #1;
    op_start = 1'b0;
    it.prod  = ref_mul(a, b);
    it.cyc   = cyc;
    sb.push_back(it);
  endtask

  task automatic wait_done(output int busy_cnt);
    bit seen;
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b);
    int bc;
    start_op(a, b);
    wait_done(bc);
    chk({name, "_busy_cycles"}, bc, LAT);
  endtask

  initial begin : monitor
    bit prev_done;
    item_t it;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && !prev_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          it = sb.pop_front();
          chk("product", result, it.prod);
          chk("latency", cyc - it.cyc, LAT);
          chk("busy_in_done", busy, 0);
        end
      end
      prev_done = (done === 1'b1);
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [N-1:0] a, b;
    logic [2*N-1:0] old_prod;
    int bc;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", result, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    run_op("3x5", 64'd3, 64'd5);
    chk("3x5_value", result, 128'd15);
    run_op("m7x6", -64'sd7, 64'd6);
    chk("m7x6_value", result, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6);
    run_op("min_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    chk("min_min_value", result, 128'h4000_0000_0000_0000_0000_0000_0000_0000);
    run_op("max_min", 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    chk("max_min_value", result, 128'hC000_0000_0000_0000_8000_0000_0000_0000);

    // start during EXEC is ignored; start in DONE reloads while result holds
    start_op(64'd1234567, -64'sd89);
    repeat (9) @(negedge clk);
    multiplicand = 64'd99;
    multiplier   = 64'd77;
    op_start     = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    wait_done(bc);
    old_prod = ref_mul(64'd1234567, -64'sd89);
    chk("ignored_start_value", result, old_prod);
    start_op(-64'sd31, -64'sd1000);
    chk("reload_done_drop", done, 0);
    chk("reload_busy", busy, 1);
    chk("reload_result_hold", result, old_prod);
    wait_done(bc);
    chk("reload_busy_cycles", bc, LAT);

    // op_clear mid-EXEC together with a start: clear wins
    start_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    repeat (14) @(negedge clk);
    op_clear = 1'b1;
    op_start = 1'b1;
    @(posedge clk);
    #1;
    void'(sb.pop_back());
    chk("clear_busy", busy, 0);
    chk("clear_done", done, 0);
    chk("clear_result", result, 0);
    @(negedge clk);
    op_clear = 1'b0;
    op_start = 1'b0;
    @(posedge clk);
    #1;
    chk("clear_stays_idle", busy, 0);
    run_op("after_clear", -64'sd5, 64'd11);

    // reset mid-EXEC together with a start
    start_op(64'd42, 64'd42);
    repeat (5) @(negedge clk);
    reset    = 1'b1;
    op_start = 1'b1;
    @(posedge clk);
    #1;
    void'(sb.pop_back());
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    @(negedge clk);
    reset    = 1'b0;
    op_start = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_stays_idle", busy, 0);

    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0:       a = 64'h8000_0000_0000_0000;
        1:       a = 64'h7FFF_FFFF_FFFF_FFFF;
        2:       a = 64'(signed'(32'($urandom_range(0, 15)) - 32'sd8));
        default: a = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 7))
        0:       b = 64'h8000_0000_0000_0000;
        1:       b = 64'hFFFF_FFFF_FFFF_FFFF;
        2:       b = 64'(signed'(32'($urandom_range(0, 15)) - 32'sd8));
        default: b = {$urandom, $urandom};
      endcase
      start_op(a, b);
      wait_done(bc);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
